// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - load/store data memory with cycle counter and sticky access-error MMIO
module data_mem_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] address,
  input  logic [N-1:0] wr_data,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   fn3,
  output logic [N-1:0] mem_out,
  output logic         mem_err,
  output logic [N-1:0] err_addr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N-1:0] CNT_ADDR  = N'(32'h0000_1000);
  localparam logic [N-1:0] STAT_ADDR = N'(32'h0000_1004);

  logic [N-1:0]  ram [DEPTH];
  logic [N-1:0]  cycle_cnt;
  logic [AW-1:0] word_idx;
  logic [4:0]    byte_off;
  logic [4:0]    half_off;
  logic          is_ram, is_cnt, is_stat, is_mmio;
  logic          ld_ok, st_ok, fault, clr;
  logic [N-1:0]  rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  assign word_idx = address[AW+1:2];
  assign byte_off = {address[1:0], 3'b000};
  assign half_off = {address[1], 4'b0000};
  assign is_ram   = (address[N-1:10] == '0);
  assign is_cnt   = (address == CNT_ADDR);
  assign is_stat  = (address == STAT_ADDR);
  assign is_mmio  = is_cnt | is_stat;

  // Alignment and fn3 legality; MMIO registers accept word accesses only.
  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (fn3)
      3'b000, 3'b100: ld_ok = 1'b1;
      3'b001, 3'b101: ld_ok = ~address[0];
      3'b010:         ld_ok = (address[1:0] == 2'b00);
      default:        ld_ok = 1'b0;
    endcase
    case (fn3)
      3'b000:  st_ok = 1'b1;
      3'b001:  st_ok = ~address[0];
      3'b010:  st_ok = (address[1:0] == 2'b00);
      default: st_ok = 1'b0;
    endcase
    if (is_mmio) begin
      ld_ok = ld_ok & (fn3 == 3'b010);
      st_ok = st_ok & (fn3 == 3'b010);
    end
  end

  assign fault = (mem_read & ~ld_ok) | (mem_write & ~st_ok);
  assign clr   = mem_write & st_ok & is_stat;

  always_comb begin
    rd_word = '0;
    if (is_ram)       rd_word = ram[word_idx];
    else if (is_cnt)  rd_word = cycle_cnt;
    else if (is_stat) rd_word = {{(N-1){1'b0}}, mem_err};
    rd_byte = rd_word[byte_off +: 8];
    rd_half = rd_word[half_off +: 16];
    mem_out = '0;
    if (reset && mem_read && !fault) begin
      case (fn3)
        3'b000:  mem_out = {{(N-8){rd_byte[7]}}, rd_byte};
        3'b001:  mem_out = {{(N-16){rd_half[15]}}, rd_half};
        3'b010:  mem_out = rd_word;
        3'b100:  mem_out = {{(N-8){1'b0}}, rd_byte};
        3'b101:  mem_out = {{(N-16){1'b0}}, rd_half};
        default: mem_out = '0;
      endcase
    end
  end

  // RAM has no reset; stores are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_write && !fault && is_ram) begin
      case (fn3)
        3'b000:  ram[word_idx][byte_off +: 8]  <= wr_data[7:0];
        3'b001:  ram[word_idx][half_off +: 16] <= wr_data[15:0];
        3'b010:  ram[word_idx]                 <= wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      mem_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + N'(1);
      // A fresh fault outranks a clear issued in the same cycle.
      if (fault) begin
        mem_err <= 1'b1;
        if (!mem_err || clr) err_addr <= address;
      end else if (clr) begin
        mem_err  <= 1'b0;
        err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - directed self-checking bench for data_mem_unit
module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  fn3;
  logic [31:0] mem_out;
  logic        mem_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  data_mem_unit #(.N(32), .DEPTH(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .wr_data  (wr_data),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .fn3      (fn3),
    .mem_out  (mem_out),
    .mem_err  (mem_err),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic w, input logic [2:0] f);
    @(negedge clk);
    address   = a;
    wr_data   = d;
    mem_read  = r;
    mem_write = w;
    fn3       = f;
    #1;
  endtask

  initial begin
    reset = 1'b0; address = 32'h0; wr_data = 32'h0;
    mem_read = 1'b0; mem_write = 1'b0; fn3 = LW;
    #2;
    check("rst_mem_err", {31'b0, mem_err}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    apply(32'h1000, 32'h0, 1'b1, 1'b0, LW);
    check("rst_mem_out", mem_out, 32'h0);
    apply(32'h0, 32'h0, 1'b0, 1'b0, LW);

    // Counter: 10 edges after release reads 10, store to it is ignored.
    reset = 1'b1;
    repeat (10) @(posedge clk);
    apply(32'h1000, 32'h0, 1'b1, 1'b0, LW);
    check("cnt_10", mem_out, 32'h0000_000A);
    apply(32'h1000, 32'h0, 1'b0, 1'b1, LW);
    check("no_read_zero", mem_out, 32'h0);
    apply(32'h1000, 32'h0, 1'b1, 1'b0, LW);
    check("cnt_store_ignored", mem_out, 32'h0000_000C);

    // Word store, then sized loads.
    apply(32'h10, 32'h8765_4321, 1'b0, 1'b1, LW);
    apply(32'h10, 32'h0, 1'b1, 1'b0, LW);
    check("lw_10", mem_out, 32'h8765_4321);
    apply(32'h10, 32'h0, 1'b1, 1'b0, LB);
    check("lb_10", mem_out, 32'h0000_0021);
    apply(32'h13, 32'h0, 1'b1, 1'b0, LB);
    check("lb_13", mem_out, 32'hFFFF_FF87);
    apply(32'h12, 32'h0, 1'b1, 1'b0, LHU);
    check("lhu_12", mem_out, 32'h0000_8765);
    apply(32'h12, 32'h0, 1'b1, 1'b0, LH);
    check("lh_12", mem_out, 32'hFFFF_8765);
    apply(32'h13, 32'h0, 1'b1, 1'b0, LBU);
    check("lbu_13", mem_out, 32'h0000_0087);

    // Partial stores preserve the other bytes.
    apply(32'h20, 32'hFFFF_FFFF, 1'b0, 1'b1, LW);
    apply(32'h21, 32'h0000_0000, 1'b0, 1'b1, LB);
    apply(32'h20, 32'h0, 1'b1, 1'b0, LW);
    check("sb_merge", mem_out, 32'hFFFF_00FF);
    apply(32'h22, 32'h0000_1234, 1'b0, 1'b1, LH);
    apply(32'h20, 32'h0, 1'b1, 1'b0, LW);
    check("sh_merge", mem_out, 32'h1234_00FF);

    // Read-before-write on the same word.
    apply(32'h20, 32'hAAAA_5555, 1'b1, 1'b1, LW);
    check("rbw_old", mem_out, 32'h1234_00FF);
    apply(32'h20, 32'h0, 1'b1, 1'b0, LW);
    check("rbw_new", mem_out, 32'hAAAA_5555);
    check("no_err_yet", {31'b0, mem_err}, 32'h0);

    // Misaligned word load faults; later faults do not overwrite err_addr.
    apply(32'h30, 32'hCAFE_F00D, 1'b0, 1'b1, LW);
    apply(32'h22, 32'h0, 1'b1, 1'b0, LW);
    check("mis_lw_out", mem_out, 32'h0);
    check("mis_lw_err_pre", {31'b0, mem_err}, 32'h0);
    apply(32'h31, 32'h0000_BEEF, 1'b0, 1'b1, LH);
    check("mis_lw_err", {31'b0, mem_err}, 32'h1);
    check("mis_lw_addr", err_addr, 32'h22);
    apply(32'h30, 32'h0, 1'b1, 1'b0, LW);
    check("mis_sh_nowrite", mem_out, 32'hCAFE_F00D);
    check("mis_sh_err", {31'b0, mem_err}, 32'h1);
    check("mis_sh_addr", err_addr, 32'h22);
    apply(32'h1004, 32'h0, 1'b1, 1'b0, LW);
    check("stat_read_1", mem_out, 32'h1);

    // Clear via SW to status, then unmapped accesses.
    apply(32'h1004, 32'h1234_5678, 1'b0, 1'b1, LW);
    apply(32'h2000, 32'h0, 1'b1, 1'b0, LW);
    check("clr_err", {31'b0, mem_err}, 32'h0);
    check("clr_addr", err_addr, 32'h0);
    check("unmapped_ld", mem_out, 32'h0);
    apply(32'h2000, 32'h5A5A_5A5A, 1'b0, 1'b1, LW);
    check("unmapped_ld_noerr", {31'b0, mem_err}, 32'h0);
    apply(32'h1004, 32'h0, 1'b1, 1'b0, LW);
    check("unmapped_st_noerr", {31'b0, mem_err}, 32'h0);
    check("stat_read_0", mem_out, 32'h0);

    // Byte access at MMIO faults; illegal store fn3 keeps first address.
    apply(32'h1000, 32'h0, 1'b1, 1'b0, LB);
    check("mmio_lb_out", mem_out, 32'h0);
    apply(32'h40, 32'h1111_1111, 1'b0, 1'b1, 3'b011);
    check("mmio_lb_err", {31'b0, mem_err}, 32'h1);
    check("mmio_lb_addr", err_addr, 32'h1000);
    apply(32'h40, 32'h0, 1'b0, 1'b0, LW);
    check("bad_fn3_addr", err_addr, 32'h1000);

    // Counter wrap.
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    address = 32'h1000; mem_read = 1'b1; mem_write = 1'b0; fn3 = LW;
    #1;
    check("cnt_max", mem_out, 32'hFFFF_FFFF);
    apply(32'h1000, 32'h0, 1'b1, 1'b0, LW);
    check("cnt_wrap", mem_out, 32'h0);

    // Asynchronous reset mid-run; RAM survives, store during reset ignored.
    @(negedge clk);
    #1;
    address = 32'h30; mem_read = 1'b1; mem_write = 1'b1; wr_data = 32'hDEAD_BEEF; fn3 = LW;
    reset = 1'b0;
    #1;
    check("arst_err", {31'b0, mem_err}, 32'h0);
    check("arst_addr", err_addr, 32'h0);
    check("arst_out", mem_out, 32'h0);
    @(negedge clk);
    mem_write = 1'b0; address = 32'h1000;
    reset = 1'b1;
    #1;
    check("arst_cnt", mem_out, 32'h0);
    apply(32'h30, 32'h0, 1'b1, 1'b0, LW);
    check("arst_ram_kept", mem_out, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter N, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 256, RAM depth in N-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  N  byte address, the execute-stage ALU result.
REQ-006 SHALL have port wr_data  input  N  store data, register rs2 value.
REQ-007 SHALL have port mem_read  input  1  load request this cycle.
REQ-008 SHALL have port mem_write  input  1  store request this cycle.
REQ-009 SHALL have port fn3  input  3  access size/sign, RISC-V funct3.
REQ-010 SHALL have port mem_out  output  N  load data to write-back.
REQ-011 SHALL have port mem_err  output  1  sticky access-error flag.
REQ-012 SHALL have port err_addr  output  N  address of first faulting access.

Function
REQ-013 SHALL decode the address map as follows:
- address[31:10]==0: RAM, word index address[9:2].
- 0x0000_1000: cycle counter, read-only.
- 0x0000_1004: error status, bit0 = mem_err.
- all other addresses: unmapped.
REQ-014 SHALL compute loads combinationally: mem_out reflects address/fn3/memory state in the same cycle, with no added latency.
REQ-015 SHALL drive mem_out = 0 when mem_read=0.
REQ-016 SHALL decode load fn3 as follows:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended half.
- 010 LW: word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
REQ-017 SHALL perform stores on the rising clk edge when mem_write=1, with fn3 000 SB, 001 SH, 010 SW.
REQ-018 SHALL select bytes by address[1:0] and halves by address[1], little-endian.
REQ-019 SHALL leave unwritten bytes of the target word unchanged on SB/SH.
REQ-020 SHALL return RAM contents before the edge when mem_read and mem_write are both 1 for the same word (read-before-write).
REQ-021 SHALL treat a request as faulting if any of the following hold:
- half access with address[0]=1;
- word access with address[1:0]!=0;
- fn3 not listed for that operation (load: 011/110/111; store: 011-111).
REQ-022 SHALL, for a faulting request: perform no write, force mem_out=0, and set mem_err at the next edge.
REQ-023 SHALL capture err_addr only when mem_err was 0 before the edge (first fault wins).
REQ-024 SHALL clear mem_err and err_addr on an SW to 0x0000_1004, regardless of data.
REQ-025 SHALL let a new fault in the same cycle as the clearing write take priority: mem_err=1, err_addr=new address.
REQ-026 SHALL make an LW of 0x0000_1004 return {31'b0, mem_err}.
REQ-027 SHALL increment the cycle counter every clk edge, wrapping 0xFFFF_FFFF -> 0.
REQ-028 SHALL make an LW of 0x0000_1000 return the pre-edge counter value.
REQ-029 SHALL ignore stores to the cycle counter.
REQ-030 SHALL make unmapped loads return 0 and unmapped stores no-ops, with no error flag.
REQ-031 SHALL allow only LW and SW at MMIO addresses; other sizes there are faulting per REQ-021.

Reset
REQ-032 SHALL, while reset=0, asynchronously force counter=0, mem_err=0, err_addr=0.
REQ-033 SHALL hold mem_out=0 while reset=0.
REQ-034 SHALL leave RAM contents unaffected by reset; they are undefined until written.
REQ-035 SHALL ignore a store coincident with an edge while reset=0.
REQ-036 SHALL start the counter from 0 at the first edge after reset deassertion.

Verification
REQ-037 SW 0x8765_4321 to 0x10, then LW 0x10 -> 0x8765_4321; LB 0x10 -> 0x0000_0021; LB 0x13 -> 0xFFFF_FF87; LHU 0x12 -> 0x0000_8765.
REQ-038 SW 0xFFFF_FFFF to 0x20, then SB 0x00 to 0x21, then LW 0x20 -> 0xFFFF_00FF; SH 0x1234 to 0x22 -> LW 0x20 = 0x1234_00FF.
REQ-039 LW 0x22 -> mem_out=0 in that cycle; next cycle mem_err=1, err_addr=0x22; then SH 0x31 -> mem_err stays 1, err_addr stays 0x22, RAM at 0x30 unchanged.
REQ-040 Release reset, wait 10 edges, LW 0x1000 -> 0x0000_000A; force counter near wrap -> 0xFFFF_FFFF then 0x0000_0000 next cycle.
REQ-041 Assert reset mid-run with mem_err=1 -> mem_err, err_addr, counter read 0 immediately (asynchronous, no clock edge needed); a RAM word written before reset still reads back.
REQ-042 SW to 0x1004 with a simultaneous misaligned fault is not possible on one port; instead SW 0x1004 -> mem_err=0, err_addr=0 next cycle; LW 0x2000 -> 0, mem_err stays 0.
